// File: rtl/rl_ram_1r1w_ctrl_pkg.sv
// rtl/rl_ram_1r1w_ctrl_pkg.sv - shared types and constants for the 1R1W RAM controller
package rl_ram_1r1w_ctrl_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int NREQ = 2;

endpackage

// File: rtl/rl_ram_rr_arb2.sv
// rtl/rl_ram_rr_arb2.sv - 2-way round-robin arbiter; favours the requester not served last
module rl_ram_rr_arb2
  import rl_ram_1r1w_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last_q,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/rl_ram_1r1w_ctrl.sv
// rtl/rl_ram_1r1w_ctrl.sv - 1R1W RAM sequencer: init sweep, write port, two round-robin readers
// Optional same-address write-to-read forwarding: RL_RAM_1R1W_CTRL_BYPASS_EN
module rl_ram_1r1w_ctrl
  import rl_ram_1r1w_ctrl_pkg::*;
#(
  parameter int               ABITS      = 10,
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] INIT_VALUE = '0,
  localparam int              BBITS      = (DBITS + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  init_done_o,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [ABITS-1:0]      waddr_i,
  input  logic [DBITS-1:0]      wdata_i,
  input  logic [BBITS-1:0]      wbe_i,
  input  logic [NREQ-1:0]       rreq_i,
  input  logic [2*ABITS-1:0]    raddr_i,
  output logic [NREQ-1:0]       rgnt_o,
  output logic [NREQ-1:0]       rvalid_o,
  output logic [DBITS-1:0]      rdata_o,
  output logic [ABITS-1:0]      ram_waddr_o,
  output logic [DBITS-1:0]      ram_din_o,
  output logic                  ram_we_o,
  output logic [BBITS-1:0]      ram_be_o,
  output logic [ABITS-1:0]      ram_raddr_o,
  output logic                  ram_re_o,
  input  logic [DBITS-1:0]      ram_dout_i
);

  localparam logic [ABITS:0] LAST_ADDR = (ABITS+1)'((1 << ABITS) - 1);
  localparam logic [ABITS:0] CNT_ONE   = (ABITS+1)'(1);

  state_t          state_q, state_d;
  logic [ABITS:0]  cnt_q, cnt_d;
  logic            init_done_q;
  logic            last_q;
  logic [NREQ-1:0] rvalid_q;
  logic [NREQ-1:0] gnt;
  logic            run;

  assign run = (state_q == RUN);

  rl_ram_rr_arb2 u_arb (
    .req    (rreq_i & {NREQ{run}}),
    .last_q (last_q),
    .gnt    (gnt)
  );

  assign rgnt_o      = gnt;
  assign ram_re_o    = |gnt;
  assign ram_raddr_o = gnt[1] ? raddr_i[2*ABITS-1:ABITS] : raddr_i[ABITS-1:0];
  assign rvalid_o    = rvalid_q;
  assign init_done_o = init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wready_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_waddr_o = waddr_i;
    ram_din_o   = wdata_i;
    ram_be_o    = wbe_i;
    case (state_q)
      INIT: begin
        ram_we_o    = 1'b1;
        ram_waddr_o = cnt_q[ABITS-1:0];
        ram_din_o   = INIT_VALUE;
        ram_be_o    = '1;
        cnt_d       = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        wready_o = 1'b1;
        ram_we_o = wvalid_i;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      last_q      <= 1'b0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == RUN);
      rvalid_q    <= gnt;
      if (|gnt) last_q <= gnt[1];
    end
  end

`ifdef RL_RAM_1R1W_CTRL_BYPASS_EN
  // The RAM returns pre-write data on a same-address collision; patch in the written bytes.
  logic             hit_q;
  logic [DBITS-1:0] wdata_q;
  logic [BBITS-1:0] wbe_q;
  logic             hit;

  assign hit = ram_we_o & ram_re_o & (ram_waddr_o == ram_raddr_o);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_q   <= 1'b0;
      wdata_q <= '0;
      wbe_q   <= '0;
    end else begin
      hit_q   <= hit;
      wdata_q <= wdata_i;
      wbe_q   <= wbe_i;
    end
  end

  always_comb begin
    rdata_o = ram_dout_i;
    for (int i = 0; i < DBITS; i++) begin
      if (hit_q && wbe_q[i/8]) rdata_o[i] = wdata_q[i];
    end
  end
`else
  assign rdata_o = ram_dout_i;
`endif

endmodule
